pipeline_hazard_ctrl: RTL

//  Hazard, forwarding and flush controller for the 5-stage pipeline (fetch/decode/execute/memory/writeback).

---
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard, forwarding and flush control for a 5-stage pipeline
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int PIPE_DEPTH   = 3,
  parameter int FWD_EN       = 1,
  parameter int BR_STAGE     = 0,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  br_taken,
  input  logic                  mem_busy,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush,
  output logic [1:0]            fwd_rs1,
  output logic [1:0]            fwd_rs2,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [FC_W-1:0]       fcnt, fcnt_nxt;
  logic [PIPE_DEPTH-1:0] sb_v, sb_ld, match1, match2;
  logic [REG_ADDR_W-1:0] sb_rd [PIPE_DEPTH];
  logic                  haz_raw, haz, advance, br_clear, new_v;

  // Scoreboard index to forwarding-mux code: EX=1, MEM=2, anything older is WB=3.
  function automatic logic [1:0] fwd_code(input int k);
    if (k == 0) return 2'd1;
    else if (k == 1) return 2'd2;
    else return 2'd3;
  endfunction

  // Compare decode sources against every live scoreboard entry; x0 never matches.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      match1[k] = id_use_rs1 && (id_rs1 != '0) && sb_v[k] && (sb_rd[k] == id_rs1);
      match2[k] = id_use_rs2 && (id_rs2 != '0) && sb_v[k] && (sb_rd[k] == id_rs2);
    end
  end

  // With bypassing only a load still in EX is too late; without it any in-flight producer blocks.
  always_comb begin
    if (FWD_EN != 0) haz_raw = (match1[0] || match2[0]) && sb_ld[0];
    else             haz_raw = (|match1) || (|match2);
    haz = haz_raw && id_valid && (state == RUN);
  end

  // Youngest producer wins: scan oldest to youngest so the last hit sticks.
  always_comb begin
    fwd_rs1 = 2'd0;
    fwd_rs2 = 2'd0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      if (match1[k]) fwd_rs1 = fwd_code(k);
      if (match2[k]) fwd_rs2 = fwd_code(k);
    end
    if (FWD_EN == 0) begin
      fwd_rs1 = 2'd0;
      fwd_rs2 = 2'd0;
    end
  end

  // Control priority: memory freeze, then taken branch, then flush tail, then RAW hazard.
  always_comb begin
    stall     = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    advance   = 1'b0;
    br_clear  = 1'b0;
    state_nxt = state;
    fcnt_nxt  = fcnt;
    if (!rst) begin
      stall = mem_busy;
    end else if (mem_busy) begin
      stall = 1'b1;
    end else begin
      advance = 1'b1;
      if (br_taken) begin
        flush     = 1'b1;
        bubble    = 1'b1;
        br_clear  = 1'b1;
        state_nxt = FLUSH;
        fcnt_nxt  = FC_W'(FLUSH_CYCLES - 1);
      end else if (state == FLUSH) begin
        flush  = 1'b1;
        bubble = 1'b1;
        if (fcnt == '0) state_nxt = RUN;
        else            fcnt_nxt  = fcnt - FC_W'(1);
      end else if (haz) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
    end
  end

  assign new_v = !bubble && id_valid && id_reg_write && (id_rd != '0);

  // FSM state and flush-length counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Scoreboard shift; a taken branch kills the wrong-path entries younger than the branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_v  <= '0;
      sb_ld <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) sb_rd[k] <= '0;
    end else if (advance) begin
      sb_v[0]  <= new_v;
      sb_rd[0] <= id_rd;
      sb_ld[0] <= new_v && id_mem_read;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        sb_v[k]  <= sb_v[k-1] && !(br_clear && ((k - 1) < BR_STAGE));
        sb_rd[k] <= sb_rd[k-1];
        sb_ld[k] <= sb_ld[k-1];
      end
    end
  end

  // Saturating count of stalled cycles, memory freezes included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
